// File: rtl/csr_reg_bank.sv
// csr_reg_bank: CSR slave with control registers, W1C event latch, pulse register, status and cycle counter
// Ports:
//    clk, rst_n   clock and synchronous active-low reset
//    csr_stb_i    per-slot write strobes
//    csr_data_i   shared write-data word
//    csr_data_o   flattened read bus, slot k at [(k+1)*DW-1 : k*DW]
//    ctrl_o       flattened control register contents
//    evt_i/evt_o  event set pulses / latched events
//    irq_o        registered OR of the latched events
//    pulse_o      one-cycle pulses written through the pulse slot
//    status_i     live status word, read back one cycle later
module csr_reg_bank #(
   parameter int unsigned CSR_DATA_BUS_WIDTH = 32,
   parameter int unsigned CSR_STROBE_BUS_WIDTH = 32,
   parameter int unsigned NUM_CTRL = 8,
   parameter logic [CSR_DATA_BUS_WIDTH-1:0] CTRL_RESET = '0
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic [CSR_STROBE_BUS_WIDTH-1:0]                  csr_stb_i,
   input  logic [CSR_DATA_BUS_WIDTH-1:0]                    csr_data_i,
   output logic [CSR_DATA_BUS_WIDTH*CSR_STROBE_BUS_WIDTH-1:0] csr_data_o,
   output logic [CSR_DATA_BUS_WIDTH*NUM_CTRL-1:0]           ctrl_o,
   input  logic [CSR_DATA_BUS_WIDTH-1:0]                    evt_i,
   output logic [CSR_DATA_BUS_WIDTH-1:0]                    evt_o,
   output logic                                             irq_o,
   output logic [CSR_DATA_BUS_WIDTH-1:0]                    pulse_o,
   input  logic [CSR_DATA_BUS_WIDTH-1:0]                    status_i
);
   localparam int unsigned DW = CSR_DATA_BUS_WIDTH;
   localparam int unsigned SW = CSR_STROBE_BUS_WIDTH;
   localparam int unsigned C = NUM_CTRL;
   if (C + 4 > SW) begin : g_bad_map
      $error("csr_reg_bank: NUM_CTRL + 4 exceeds CSR_STROBE_BUS_WIDTH");
   end
   logic [DW-1:0] ctrl_q [C];
   logic [DW-1:0] ctrl_d [C];
   logic [DW-1:0] evt_q, evt_d, pulse_q, pulse_d, status_q, cnt_q, cnt_d;
   logic          irq_q;
   logic          unused_stb;
   // Strobes of the status and unmapped slots intentionally have no effect.
   assign unused_stb = ^csr_stb_i;
   always_comb begin
      for (int i = 0; i < C; i++) ctrl_d[i] = csr_stb_i[i] ? csr_data_i : ctrl_q[i];
      // Set is OR-ed in after the clear, so a simultaneous event wins.
      evt_d = (evt_q & ~(csr_stb_i[C] ? csr_data_i : '0)) | evt_i;
      pulse_d = csr_stb_i[C+1] ? csr_data_i : '0;
      cnt_d = csr_stb_i[C+3] ? csr_data_i : cnt_q + DW'(1);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < C; i++) ctrl_q[i] <= CTRL_RESET;
         evt_q <= '0;
         irq_q <= 1'b0;
         pulse_q <= '0;
         status_q <= '0;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < C; i++) ctrl_q[i] <= ctrl_d[i];
         evt_q <= evt_d;
         irq_q <= |evt_q;
         pulse_q <= pulse_d;
         status_q <= status_i;
         cnt_q <= cnt_d;
      end
   end
   for (genvar k = 0; k < SW; k++) begin : g_rd
      if (k < C) begin : g_ctrl
         assign csr_data_o[k*DW +: DW] = ctrl_q[k];
         assign ctrl_o[k*DW +: DW] = ctrl_q[k];
      end else if (k == C) begin : g_evt
         assign csr_data_o[k*DW +: DW] = evt_q;
      end else if (k == C + 2) begin : g_status
         assign csr_data_o[k*DW +: DW] = status_q;
      end else if (k == C + 3) begin : g_cnt
         assign csr_data_o[k*DW +: DW] = cnt_q;
      end else begin : g_zero
         assign csr_data_o[k*DW +: DW] = '0;
      end
   end
   assign evt_o = evt_q;
   assign irq_o = irq_q;
   assign pulse_o = pulse_q;
endmodule

// File: tb/tb_csr_reg_bank.sv
// tb_csr_reg_bank: scoreboard bench for csr_reg_bank against a behavioural register-map model
module tb_csr_reg_bank;
   localparam int DW = 32;
   localparam int SW = 32;
   localparam int C = 8;
   typedef struct packed {
      logic [SW*DW-1:0] rd;
      logic [C*DW-1:0]  ctrl;
      logic [DW-1:0]    evt;
      logic             irq;
      logic [DW-1:0]    pulse;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n;
   logic [SW-1:0] stb;
   logic [DW-1:0] data, evt_in, status_in;
   logic [SW*DW-1:0] csr_data_o;
   logic [C*DW-1:0] ctrl_o;
   logic [DW-1:0] evt_o, pulse_o;
   logic irq_o;
   always #5 clk = ~clk;
   csr_reg_bank #(.CSR_DATA_BUS_WIDTH(DW), .CSR_STROBE_BUS_WIDTH(SW), .NUM_CTRL(C), .CTRL_RESET('0)) dut (
      .clk(clk), .rst_n(rst_n), .csr_stb_i(stb), .csr_data_i(data), .csr_data_o(csr_data_o),
      .ctrl_o(ctrl_o), .evt_i(evt_in), .evt_o(evt_o), .irq_o(irq_o), .pulse_o(pulse_o), .status_i(status_in)
   );
   logic [DW-1:0] m_ctrl [C];
   logic [DW-1:0] m_latch, m_pulse, m_status, m_cnt;
   logic m_irq;
   exp_t sb [$];
   exp_t mx;
   int checks = 0;
   int passed = 0;
   function automatic logic [DW-1:0] slot_val(input int k);
      if (k < C) return m_ctrl[k];
      if (k == C) return m_latch;
      if (k == C + 2) return m_status;
      if (k == C + 3) return m_cnt;
      return '0;
   endfunction
   task automatic check(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
      checks++;
      if (a === e) passed++;
      else $display("FAIL %s: got %h expected %h", n, a, e);
   endtask
   task automatic apply(input logic r, input logic [SW-1:0] s, input logic [DW-1:0] d, input logic [DW-1:0] e, input logic [DW-1:0] st);
      exp_t x;
      rst_n = r; stb = s; data = d; evt_in = e; status_in = st;
      if (!r) begin
         for (int k = 0; k < C; k++) m_ctrl[k] = '0;
         m_latch = '0; m_pulse = '0; m_status = '0; m_cnt = '0; m_irq = 1'b0;
      end else begin
         m_irq = (m_latch != 0);
         m_latch = (m_latch & ~(s[C] ? d : '0)) | e;
         for (int k = 0; k < C; k++) if (s[k]) m_ctrl[k] = d;
         m_pulse = s[C+1] ? d : '0;
         m_status = st;
         m_cnt = s[C+3] ? d : m_cnt + 1;
      end
      for (int k = 0; k < SW; k++) x.rd[k*DW +: DW] = slot_val(k);
      for (int k = 0; k < C; k++) x.ctrl[k*DW +: DW] = m_ctrl[k];
      x.evt = m_latch; x.irq = m_irq; x.pulse = m_pulse;
      @(posedge clk);
      sb.push_back(x);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(1'b1, '0, '0, '0, status_in);
   endtask
   task automatic wr(input int slot, input logic [DW-1:0] d);
      apply(1'b1, 32'h1 << slot, d, '0, status_in);
   endtask
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            mx = sb.pop_front();
            for (int k = 0; k < SW; k++) check($sformatf("slot%0d", k), csr_data_o[k*DW +: DW], mx.rd[k*DW +: DW]);
            for (int k = 0; k < C; k++) check($sformatf("ctrl_o%0d", k), ctrl_o[k*DW +: DW], mx.ctrl[k*DW +: DW]);
            check("evt_o", evt_o, mx.evt);
            check("irq_o", DW'(irq_o), DW'(mx.irq));
            check("pulse_o", pulse_o, mx.pulse);
         end
      end
   end
   initial begin
      status_in = '0;
      apply(1'b0, '0, '0, '0, '0);
      apply(1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hF, '0);
      idle(2);
      wr(3, 32'hA5A5_0003);
      idle(2);
      apply(1'b1, '0, '0, 32'h5, status_in);
      idle(2);
      wr(C, 32'h1);
      idle(1);
      apply(1'b1, 32'h1 << C, 32'h4, 32'h4, status_in);
      idle(2);
      wr(C + 1, 32'h8000_0001);
      idle(2);
      wr(C + 1, 32'h1);
      wr(C + 1, 32'h2);
      idle(1);
      wr(C + 3, 32'hFFFF_FFFE);
      idle(4);
      apply(1'b1, '0, '0, '0, 32'h1234_5678);
      idle(2);
      wr(SW - 1, 32'hFFFF_FFFF);
      idle(2);
      apply(1'b1, (32'h1 << 1) | (32'h1 << 5), 32'h0BAD_F00D, 32'h30, status_in);
      idle(3);
      apply(1'b0, (32'h1 << 2) | (32'h1 << (C + 1)) | (32'h1 << (C + 3)), 32'h7777_7777, 32'h3, 32'h55);
      idle(3);
      apply(1'b1, (32'h1 << 0) | (32'h1 << C) | (32'h1 << (C + 1)) | (32'h1 << (C + 3)), 32'h0F0F_0F0F, 32'h100, 32'h9);
      idle(2);
      for (int i = 0; i < 1500; i++)
         apply($urandom_range(0, 99) != 0, $urandom & $urandom & $urandom, $urandom,
               $urandom & $urandom & $urandom & $urandom, $urandom);
      idle(2);
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
